// File: rtl/shapool_job_ctrl.sv
// Job sequencer for one shapool instance: loads a job, runs the pool, rebuilds the winning nonce.
// Optional: define SHAPOOL_JOB_CTRL_RESUME_EN to resume the search after each reported win.
module shapool_job_ctrl #(
    parameter int POOL_SIZE      = 2,
    parameter int POOL_SIZE_LOG2 = 1,
    parameter int NONCE_LAG      = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_sha_state,
    input  logic [95:0]  job_message_head,
    input  logic [7:0]   job_nonce_start_MSB,
    input  logic         abort,
    output logic         pool_reset_n,
    output logic [255:0] pool_sha_state,
    output logic [95:0]  pool_message_head,
    output logic [7:0]   pool_nonce_start_MSB,
    input  logic         pool_success,
    input  logic [31:0]  pool_nonce,
    input  logic [7:0]   pool_match_flags,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [31:0]  result_nonce,
    output logic [7:0]   result_flags,
    output logic         busy,
    output logic         exhausted
);

    localparam int NL = 32 - POOL_SIZE_LOG2;
    localparam int IW = NL + 2;
    localparam logic [IW-1:0] ITER_LIMIT = IW'((64'd1 << NL) + 64'(NONCE_LAG));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_REPORT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           load_cnt_q, load_cnt_d;
    logic [5:0]     phase_q, phase_d;
    logic [IW-1:0]  iter_q, iter_d;
    logic           exhausted_q, exhausted_d;
    logic           job_ready_q, job_ready_d;
    logic [255:0]   sha_q, sha_d;
    logic [95:0]    head_q, head_d;
    logic [7:0]     msb_q, msb_d;
    logic [31:0]    res_nonce_q, res_nonce_d;
    logic [7:0]     res_flags_q, res_flags_d;

    logic [POOL_SIZE_LOG2-1:0] win_unit;
    logic [NL-1:0]             win_lower;
    logic [31:0]               win_word;
    logic                      unused_bits;

    // Lowest-indexed matching pipeline wins; the loop runs high-to-low so the last hit sticks.
    always_comb begin
        win_unit = '0;
        for (int i = POOL_SIZE - 1; i >= 0; i--) begin
            if (pool_match_flags[i]) win_unit = POOL_SIZE_LOG2'(i);
        end
        win_lower = pool_nonce[NL-1:0] - NL'(NONCE_LAG);
        win_word  = {win_unit, win_lower} ^ {msb_q, 24'b0};
    end

    assign unused_bits = ^pool_nonce;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        phase_d     = phase_q;
        iter_d      = iter_q;
        exhausted_d = exhausted_q;
        sha_d       = sha_q;
        head_d      = head_q;
        msb_d       = msb_q;
        res_nonce_d = res_nonce_q;
        res_flags_d = res_flags_q;

        if (abort && (state_q inside {S_LOAD, S_RUN, S_REPORT})) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (job_valid && job_ready_q) begin
                        sha_d      = job_sha_state;
                        head_d     = job_message_head;
                        msb_d      = job_nonce_start_MSB;
                        load_cnt_d = 1'b0;
                        state_d    = S_LOAD;
                    end
                end
                S_LOAD: begin
                    phase_d     = '0;
                    iter_d      = '0;
                    exhausted_d = 1'b0;
                    if (load_cnt_q) state_d = S_RUN;
                    else            load_cnt_d = 1'b1;
                end
                S_RUN, S_REPORT: begin
                    // Counters track the pool round in both states; iterations saturate at the limit.
                    phase_d = phase_q + 6'd1;
                    if (phase_q == 6'd63 && iter_q != ITER_LIMIT) iter_d = iter_q + IW'(1);
                    if (state_q == S_RUN) begin
                        if (pool_success && phase_q == 6'd0) begin
                            res_nonce_d = win_word;
                            res_flags_d = pool_match_flags;
                            state_d     = S_REPORT;
                        end else if (iter_q == ITER_LIMIT) begin
                            exhausted_d = 1'b1;
                            state_d     = S_DONE;
                        end
                    end else if (result_ready) begin
`ifdef SHAPOOL_JOB_CTRL_RESUME_EN
                        state_d = S_RUN;
`else
                        exhausted_d = 1'b0;
                        state_d     = S_DONE;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        job_ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            load_cnt_q  <= 1'b0;
            phase_q     <= '0;
            iter_q      <= '0;
            exhausted_q <= 1'b0;
            job_ready_q <= 1'b0;
            sha_q       <= '0;
            head_q      <= '0;
            msb_q       <= '0;
            res_nonce_q <= '0;
            res_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            phase_q     <= phase_d;
            iter_q      <= iter_d;
            exhausted_q <= exhausted_d;
            job_ready_q <= job_ready_d;
            sha_q       <= sha_d;
            head_q      <= head_d;
            msb_q       <= msb_d;
            res_nonce_q <= res_nonce_d;
            res_flags_q <= res_flags_d;
        end
    end

    assign job_ready            = job_ready_q;
    assign pool_reset_n         = (state_q == S_RUN) || (state_q == S_REPORT);
    assign pool_sha_state       = sha_q;
    assign pool_message_head    = head_q;
    assign pool_nonce_start_MSB = msb_q;
    assign result_valid         = (state_q == S_REPORT);
    assign result_nonce         = res_nonce_q;
    assign result_flags         = res_flags_q;
    assign busy                 = state_q inside {S_LOAD, S_RUN, S_REPORT};
    assign exhausted            = exhausted_q;

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// Scoreboard bench for shapool_job_ctrl: dut0 uses default parameters, dut1 a reduced nonce space (NL = 4).
module tb_shapool_job_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [255:0] job_sha  = '0;
    logic [95:0]  job_head = '0;
    logic [7:0]   job_msb  = '0;
    logic [31:0]  p_nonce  = '0;
    logic [7:0]   p_flags  = '0;

    logic         job_valid0 = 1'b0, abort0 = 1'b0, success0 = 1'b0, result_ready0 = 1'b1;
    logic         job_ready0, pool_reset_n0, result_valid0, busy0, exhausted0;
    logic [255:0] pool_sha0;
    logic [95:0]  pool_head0;
    logic [7:0]   pool_msb0, result_flags0;
    logic [31:0]  result_nonce0;

    logic         job_valid1 = 1'b0, abort1 = 1'b0, success1 = 1'b0, result_ready1 = 1'b1;
    logic         job_ready1, pool_reset_n1, result_valid1, busy1, exhausted1;
    logic [255:0] pool_sha1;
    logic [95:0]  pool_head1;
    logic [7:0]   pool_msb1, result_flags1;
    logic [31:0]  result_nonce1;

    shapool_job_ctrl #(.POOL_SIZE(2), .POOL_SIZE_LOG2(1), .NONCE_LAG(2)) dut0 (
        .clk(clk), .reset(rst),
        .job_valid(job_valid0), .job_ready(job_ready0),
        .job_sha_state(job_sha), .job_message_head(job_head), .job_nonce_start_MSB(job_msb),
        .abort(abort0), .pool_reset_n(pool_reset_n0),
        .pool_sha_state(pool_sha0), .pool_message_head(pool_head0), .pool_nonce_start_MSB(pool_msb0),
        .pool_success(success0), .pool_nonce(p_nonce), .pool_match_flags(p_flags),
        .result_valid(result_valid0), .result_ready(result_ready0),
        .result_nonce(result_nonce0), .result_flags(result_flags0),
        .busy(busy0), .exhausted(exhausted0)
    );

    shapool_job_ctrl #(.POOL_SIZE(2), .POOL_SIZE_LOG2(28), .NONCE_LAG(2)) dut1 (
        .clk(clk), .reset(rst),
        .job_valid(job_valid1), .job_ready(job_ready1),
        .job_sha_state(job_sha), .job_message_head(job_head), .job_nonce_start_MSB(job_msb),
        .abort(abort1), .pool_reset_n(pool_reset_n1),
        .pool_sha_state(pool_sha1), .pool_message_head(pool_head1), .pool_nonce_start_MSB(pool_msb1),
        .pool_success(success1), .pool_nonce(p_nonce), .pool_match_flags(p_flags),
        .result_valid(result_valid1), .result_ready(result_ready1),
        .result_nonce(result_nonce1), .result_flags(result_flags1),
        .busy(busy1), .exhausted(exhausted1)
    );

    int total  = 0;
    int passed = 0;
    logic [39:0] exp_q0[$];
    logic [39:0] exp_q1[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // Stub pool round for dut0: synchronous reset while pool_reset_n is low.
    logic [5:0] tb_round;
    always @(posedge clk or posedge rst) begin
        if (rst)                 tb_round <= '0;
        else if (!pool_reset_n0) tb_round <= '0;
        else                     tb_round <= tb_round + 6'd1;
    end

    always @(negedge clk) begin
        if (!rst && result_valid0 && result_ready0) begin
            check("res0_expected", 64'(exp_q0.size() != 0), 64'd1);
            if (exp_q0.size() != 0) check("res0_nonce_flags", {result_nonce0, result_flags0}, exp_q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && result_valid1 && result_ready1) begin
            check("res1_expected", 64'(exp_q1.size() != 0), 64'd1);
            if (exp_q1.size() != 0) check("res1_nonce_flags", {result_nonce1, result_flags1}, exp_q1.pop_front());
        end
    end

    task automatic start_job0(input logic [7:0] msb);
        int n = 0;
        @(negedge clk);
        job_msb    = msb;
        job_valid0 = 1'b1;
        while (!job_ready0 && n < 20) begin @(negedge clk); n++; end
        check("job_ready_high", job_ready0, 1);
        @(posedge clk);
        #1 job_valid0 = 1'b0;
        @(negedge clk);
        check("load1_pool_reset_n", pool_reset_n0, 0);
        check("load1_job_ready", job_ready0, 0);
        check("load1_busy", busy0, 1);
        @(negedge clk);
        check("load2_pool_reset_n", pool_reset_n0, 0);
        @(negedge clk);
        check("run_pool_reset_n", pool_reset_n0, 1);
        check("pool_params", 64'({pool_sha0, pool_head0, pool_msb0} == {job_sha, job_head, msb}), 64'd1);
    endtask

    // Drive a one-cycle success at pool round 0; push the expected result when it should be reported.
    task automatic win0(input logic [31:0] nonce, input logic [7:0] flags,
                        input logic [31:0] exp_nonce, input bit expect_it);
        int n = 0;
        while (tb_round != 6'd0 && n < 100) begin @(negedge clk); n++; end
        p_nonce  = nonce;
        p_flags  = flags;
        success0 = 1'b1;
        if (expect_it) exp_q0.push_back({exp_nonce, flags});
        @(negedge clk);
        success0 = 1'b0;
    endtask

    task automatic wait_handshake0();
        int n = 0;
        while (!(result_valid0 && result_ready0) && n < 400) begin @(negedge clk); n++; end
        check("handshake_seen", 64'(result_valid0 && result_ready0), 64'd1);
        @(negedge clk);
    endtask

    task automatic post_handshake0();
        check("post_result_valid", result_valid0, 0);
`ifdef SHAPOOL_JOB_CTRL_RESUME_EN
        check("post_busy_resume", busy0, 1);
        check("post_pool_reset_n_resume", pool_reset_n0, 1);
`else
        check("post_busy_done", busy0, 0);
        check("post_pool_reset_n_done", pool_reset_n0, 0);
        check("post_exhausted_done", exhausted0, 0);
        check("post_job_ready_done", job_ready0, 1);
`endif
    endtask

    task automatic abort_job0();
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        check("abort_busy", busy0, 0);
        check("abort_pool_reset_n", pool_reset_n0, 0);
        check("abort_result_valid", result_valid0, 0);
        check("abort_job_ready", job_ready0, 1);
    endtask

    task automatic finish_job0();
`ifdef SHAPOOL_JOB_CTRL_RESUME_EN
        abort_job0();
`endif
    endtask

    initial begin
        int n;
        int cnt;
        bit changed;

        #2;
        check("rst_job_ready", job_ready0, 0);
        check("rst_pool_reset_n", pool_reset_n0, 0);
        check("rst_result_valid", result_valid0, 0);
        check("rst_busy", busy0, 0);
        check("rst_exhausted", exhausted0, 0);
        check("rst_result", {result_nonce0, result_flags0}, 0);
        check("rst_pool_params", 64'({pool_sha0, pool_head0, pool_msb0} == '0), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_job_ready", job_ready0, 1);
        check("idle_busy", busy0, 0);

        // Basic win: unit 1, lower 5-2 = 3.
        job_sha  = {8{32'hDEADBEEF}};
        job_head = 96'h0123_4567_89AB_CDEF_0F1E_2D3C;
        start_job0(8'h00);
        win0(32'd5, 8'h02, 32'h8000_0003, 1'b1);
        wait_handshake0();
        post_handshake0();
        finish_job0();

        // Segment XOR: 0x80 ^ 0xA5 = 0x25.
        job_sha  = {8{32'h1234_5678}};
        job_head = 96'hA5A5_5A5A_F00D_CAFE_0000_0001;
        start_job0(8'hA5);
        win0(32'd5, 8'h02, 32'h2500_0003, 1'b1);
        wait_handshake0();
        post_handshake0();
        finish_job0();

        // A success off phase 0 is ignored; then lag wrap: 1 - 2 mod 2^31.
        start_job0(8'h00);
        repeat (5) @(negedge clk);
        p_nonce  = 32'd40;
        p_flags  = 8'h02;
        success0 = 1'b1;
        @(negedge clk);
        success0 = 1'b0;
        win0(32'd1, 8'h01, 32'h7FFF_FFFF, 1'b1);
        wait_handshake0();
        post_handshake0();
        finish_job0();

        // Backpressure: flags 0x03 picks unit 0; a later success must not disturb the held result.
        start_job0(8'h00);
        result_ready0 = 1'b0;
        win0(32'd9, 8'h03, 32'h0000_0007, 1'b1);
        changed = 1'b0;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (c > 10 && n == 0 && tb_round == 6'd0) begin
                p_nonce  = 32'h77;
                p_flags  = 8'h01;
                success0 = 1'b1;
                n = 1;
            end else begin
                success0 = 1'b0;
            end
            @(negedge clk);
            if ({result_nonce0, result_flags0} != {32'h0000_0007, 8'h03}) changed = 1'b1;
        end
        success0 = 1'b0;
        check("bp_second_success_driven", 64'(n), 64'd1);
        check("bp_fields_stable", changed, 0);
        check("bp_result_valid", result_valid0, 1);
        result_ready0 = 1'b1;
        wait_handshake0();
        post_handshake0();
`ifdef SHAPOOL_JOB_CTRL_RESUME_EN
        win0(32'h20, 8'h01, 32'h0000_001E, 1'b1);
        wait_handshake0();
        post_handshake0();
`endif
        finish_job0();

        // Abort mid-RUN.
        start_job0(8'h11);
        repeat (10) @(negedge clk);
        abort_job0();

        // Exhaustion on dut1: NL = 4, limit 18 iterations -> 18*64 RUN cycles plus the cycle that sees the limit.
        @(negedge clk);
        job_msb    = 8'h00;
        job_valid1 = 1'b1;
        check("dut1_job_ready", job_ready1, 1);
        @(posedge clk);
        #1 job_valid1 = 1'b0;
        n = 0;
        while (!pool_reset_n1 && n < 10) begin @(negedge clk); n++; end
        check("dut1_run_entered", pool_reset_n1, 1);
        cnt = 0;
        n = 0;
        while (!exhausted1 && n < 3000) begin
            if (pool_reset_n1) cnt++;
            @(negedge clk);
            n++;
        end
        check("exh_flag", exhausted1, 1);
        check("exh_run_cycles", 64'(cnt), 64'd1153);
        check("exh_pool_reset_n", pool_reset_n1, 0);
        check("exh_busy", busy1, 0);
        check("exh_job_ready", job_ready1, 1);

        // Win on the same cycle the limit is reached takes priority: unit 1, lower (5-2) mod 16.
        job_valid1 = 1'b1;
        @(posedge clk);
        #1 job_valid1 = 1'b0;
        n = 0;
        while (!pool_reset_n1 && n < 10) begin @(negedge clk); n++; end
        check("exh_cleared_by_load", exhausted1, 0);
        repeat (1152) @(negedge clk);
        p_nonce  = 32'd5;
        p_flags  = 8'h02;
        success1 = 1'b1;
        exp_q1.push_back({32'h0000_0013, 8'h02});
        @(negedge clk);
        success1 = 1'b0;
        check("prio_result_valid", result_valid1, 1);
        check("prio_not_exhausted", exhausted1, 0);
        @(negedge clk);
`ifdef SHAPOOL_JOB_CTRL_RESUME_EN
        n = 0;
        while (!exhausted1 && n < 5) begin @(negedge clk); n++; end
        check("prio_exhausted_after_resume", exhausted1, 1);
`else
        check("prio_done_exhausted", exhausted1, 0);
        check("prio_done_busy", busy1, 0);
`endif

        // Asynchronous reset while a result is held.
        start_job0(8'h3C);
        result_ready0 = 1'b0;
        win0(32'd5, 8'h02, 32'h0, 1'b0);
        check("pre_reset_result_valid", result_valid0, 1);
        rst = 1'b1;
        #1;
        check("arst_result_valid", result_valid0, 0);
        check("arst_pool_reset_n", pool_reset_n0, 0);
        check("arst_busy", busy0, 0);
        check("arst_job_ready", job_ready0, 0);
        check("arst_result", {result_nonce0, result_flags0}, 0);
        check("arst_pool_msb", pool_msb0, 0);
        @(negedge clk);
        rst = 1'b0;
        result_ready0 = 1'b1;
        repeat (2) @(negedge clk);

        check("scoreboard0_drained", 64'(exp_q0.size()), 64'd0);
        check("scoreboard1_drained", 64'(exp_q1.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shapool_job_ctrl.md
Name: shapool_job_ctrl

Overview:
- Sequences one `shapool` instance: accepts a job, resets and releases the pool, watches `success`, and rebuilds the 32-bit winning nonce.
- Reports each win through a valid/ready result port and detects exhaustion of the nonce space.
- Sits between the host/SPI job interface and the pool. It owns the pool's `reset_n` and job-parameter registers.

Parameters:
- POOL_SIZE, 2, number of pool pipelines; must be a power of 2 and at most 8.
- POOL_SIZE_LOG2, 1, log2(POOL_SIZE); must be at least 1.
- NONCE_LAG, 2, number of nonce increments between the hashed nonce and the pool `nonce` value sampled when `success` is high.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- job_valid  in  1  a job is presented.
- job_ready  out  1  controller accepts the job this cycle.
- job_sha_state  in  256  midstate for the job.
- job_message_head  in  96  message head for the job.
- job_nonce_start_MSB  in  8  nonce segment for the job.
- abort  in  1  one-cycle pulse that cancels the current job.
- pool_reset_n  out  1  drives pool `reset_n`.
- pool_sha_state  out  256  registered job parameter to the pool.
- pool_message_head  out  96  registered job parameter to the pool.
- pool_nonce_start_MSB  out  8  registered job parameter to the pool.
- pool_success  in  1  pool `success`.
- pool_nonce  in  32  pool `nonce`.
- pool_match_flags  in  8  pool `match_flags`.
- result_valid  out  1  a result is held on the result port.
- result_ready  in  1  sink accepts the result.
- result_nonce  out  32  winning nonce.
- result_flags  out  8  match flags captured with the win.
- busy  out  1  high in any state other than IDLE and DONE.
- exhausted  out  1  the job ended without a further win.

Behaviour:
- NL = 32 - POOL_SIZE_LOG2.
- Reset values:
  - state = IDLE.
  - pool_reset_n = 0.
  - All pool_* parameter registers = 0.
  - job_ready = 0, result_valid = 0, busy = 0, exhausted = 0.
  - result_nonce = 0, result_flags = 0.
- IDLE:
  - job_ready = 1.
  - On job_valid & job_ready: latch all three job fields into the pool_* registers and go to LOAD.
- LOAD:
  - Hold pool_reset_n = 0 for exactly 2 cycles. The pool reset is synchronous, so it must see at least one edge.
  - Clear the 6-bit phase counter and the iteration counter (width NL+2).
  - Clear `exhausted`, then go to RUN.
- RUN:
  - pool_reset_n = 1.
  - The phase counter increments every cycle, in lockstep with the pool round (phase 0 equals pool round 0).
  - The iteration counter increments when phase wraps from 63 to 0.
- Win in RUN: pool_success = 1 (only counted when phase = 0).
  - result_flags <= pool_match_flags.
  - unit = index of the lowest set bit of pool_match_flags[POOL_SIZE-1:0].
  - win_lower = pool_nonce[NL-1:0] - NONCE_LAG, modulo 2^NL.
  - result_nonce <= {unit, win_lower} ^ {pool_nonce_start_MSB, 24'b0}.
  - Go to REPORT.
- Exhaustion in RUN: the iteration counter reaches 2^NL + NONCE_LAG with no win in that window.
  - Set exhausted = 1, drive pool_reset_n = 0, go to DONE.
- Simultaneous events: if a win and exhaustion occur in the same cycle, the win takes priority. Exhaustion is re-evaluated after REPORT.
- REPORT:
  - result_valid = 1; all result fields stay stable until result_valid & result_ready.
  - The pool keeps running; phase and iteration counters keep counting.
  - A pool_success during REPORT is dropped. The first captured result is never overwritten.
  - On handshake, the next state depends on RESUME_EN (see Optional Feature).
- DONE:
  - pool_reset_n = 0, job_ready = 1.
  - A new job is accepted as in IDLE and goes to LOAD.
  - `exhausted` holds its value until the next LOAD.
- abort in any state except IDLE or DONE:
  - Next cycle: state = IDLE, pool_reset_n = 0, result_valid = 0.
  - `exhausted` is left unchanged.
  - abort has priority over every other event.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous).

Optional Feature:
- Macro: SHAPOOL_JOB_CTRL_RESUME_EN.
- Defined: after the REPORT handshake, return to RUN with no pool reset. Counters continue, so the search carries on and further wins are reported. Wins that landed during REPORT are lost.
- Undefined: after the REPORT handshake, drive pool_reset_n = 0 and go to DONE with exhausted = 0. That is one result per job.

Test Plan:
- Job handshake: job_valid with nonce_start_MSB = 0x00 -> job_ready high for 1 cycle; pool_reset_n low for exactly 2 cycles, then high; pool_* registers equal the job fields.
- Basic win: POOL_SIZE = 2, NONCE_LAG = 2, stub pool gives success = 1 at phase 0 with match_flags = 0x02 and nonce = 5 -> result_nonce = 0x80000003, result_flags = 0x02.
- Segment XOR: same win with nonce_start_MSB = 0xA5 -> result_nonce = 0x25000003.
- Lag wrap: win with match_flags = 0x01 and nonce = 1 -> win_lower = 0x7FFFFFFF, result_nonce = 0x7FFFFFFF.
- Backpressure: result_ready held low for 200 cycles with a second success in that window -> result fields unchanged; with the macro defined, return to RUN after ready, otherwise DONE with exhausted = 0.
- Exhaustion and abort:
  - NL reduced through a bench override of POOL_SIZE_LOG2, no success -> exhausted = 1 after (2^NL + 2) × 64 cycles of RUN.
  - abort pulse mid-RUN -> IDLE and pool_reset_n = 0 on the next cycle.
